// File: rtl/ysyx_22041412_lsu.sv
// Load/store unit for the ysyx_22041412 RV64 core. It runs one data-memory access per
// request on an 8-byte bus, extends load data, and completes bad requests with an error.
module ysyx_22041412_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_load,
   input  logic        in_store,
   input  logic [2:0]  in_func3,
   input  logic [63:0] in_addr,
   input  logic [63:0] in_wdata,
   input  logic [4:0]  in_rd,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata,
   output logic        out_valid,
   output logic [63:0] out_rdata,
   output logic [4:0]  out_rd,
   output logic        out_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic        r_we;
   logic [63:0] r_addr;
   logic [2:0]  r_off;
   logic [2:0]  r_func3;
   logic [63:0] r_wdata;
   logic [7:0]  r_wmask;
   logic [4:0]  r_rd;
   logic        r_err;
   logic [63:0] r_rdata;

   logic        w_accept;
   logic        w_is_store;
   logic        w_illegal;
   logic [2:0]  w_align_mask;
   logic        w_misaligned;
   logic        w_err;
   logic [3:0]  w_size;
   logic [3:0]  w_lane_end;
   logic [7:0]  w_lane_en;
   logic [63:0] w_wdata_sh;
   logic [63:0] w_rshift;
   logic [63:0] w_load_ext;

   // Request decode, evaluated only while IDLE.
   assign w_accept     = (r_state == IDLE) && in_valid;
   assign w_is_store   = in_store && !in_load;
   assign w_illegal    = (in_load == in_store)
                       || (in_store && in_func3[2])
                       || (in_load && (in_func3 == 3'b111));
   assign w_size       = 4'd1 << in_func3[1:0];
   assign w_misaligned = |(in_addr[2:0] & w_align_mask);
   assign w_err        = w_illegal || w_misaligned;

   always_comb begin
      w_align_mask = 3'b000;
      case (in_func3[1:0])
         2'd0:    w_align_mask = 3'b000;
         2'd1:    w_align_mask = 3'b001;
         2'd2:    w_align_mask = 3'b011;
         default: w_align_mask = 3'b111;
      endcase
   end

   // A lane is written when it lies in [offset, offset + size); aligned ops never wrap.
   assign w_lane_end = {1'b0, in_addr[2:0]} + w_size;

   for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      localparam logic [3:0] LANE = 4'(gi);
      assign w_lane_en[gi] = (LANE >= {1'b0, in_addr[2:0]}) && (LANE < w_lane_end);
   end

   assign w_wdata_sh = in_wdata << {in_addr[2:0], 3'b000};

   // Load extraction from the registered byte offset and funct3.
   assign w_rshift = mem_rdata >> {r_off, 3'b000};

   always_comb begin
      w_load_ext = w_rshift;
      case (r_func3)
         3'b000:  w_load_ext = {{56{w_rshift[7]}},  w_rshift[7:0]};
         3'b001:  w_load_ext = {{48{w_rshift[15]}}, w_rshift[15:0]};
         3'b010:  w_load_ext = {{32{w_rshift[31]}}, w_rshift[31:0]};
         3'b100:  w_load_ext = {56'd0, w_rshift[7:0]};
         3'b101:  w_load_ext = {48'd0, w_rshift[15:0]};
         3'b110:  w_load_ext = {32'd0, w_rshift[31:0]};
         default: w_load_ext = w_rshift;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_state_next = w_err ? DONE : REQ;
            end
         end
         REQ: begin
            if (mem_ready) begin
               w_state_next = r_we ? DONE : WAIT_R;
            end
         end
         WAIT_R: begin
            if (mem_rvalid) begin
               w_state_next = DONE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Request fields are latched once at acceptance so they stay stable under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we    <= 1'b0;
         r_addr  <= 64'd0;
         r_off   <= 3'd0;
         r_func3 <= 3'd0;
         r_wdata <= 64'd0;
         r_wmask <= 8'd0;
         r_rd    <= 5'd0;
         r_err   <= 1'b0;
         r_rdata <= 64'd0;
      end else begin
         if (w_accept) begin
            r_we    <= w_is_store;
            r_addr  <= {in_addr[63:3], 3'b000};
            r_off   <= in_addr[2:0];
            r_func3 <= in_func3;
            r_wdata <= w_is_store ? w_wdata_sh : 64'd0;
            r_wmask <= w_is_store ? w_lane_en : 8'd0;
            r_rd    <= in_rd;
            r_err   <= w_err;
            r_rdata <= 64'd0;
         end
         if ((r_state == WAIT_R) && mem_rvalid) begin
            r_rdata <= w_load_ext;
         end
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign mem_valid = (r_state == REQ);
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_wmask = r_wmask;
   assign out_valid = (r_state == DONE);
   assign out_rdata = r_rdata;
   assign out_rd    = r_rd;
   assign out_err   = r_err;

endmodule

// File: tb/tb_ysyx_22041412_lsu.sv
// Bench for ysyx_22041412_lsu: directed ops against a byte-level reference model,
// checked every cycle, plus literal expectations on selected transactions.
`timescale 1ns/1ps
module tb_ysyx_22041412_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_load = 1'b0;
   logic        in_store = 1'b0;
   logic [2:0]  in_func3 = 3'd0;
   logic [63:0] in_addr = 64'd0;
   logic [63:0] in_wdata = 64'd0;
   logic [4:0]  in_rd = 5'd0;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_rvalid = 1'b0;
   logic [63:0] mem_rdata = 64'd0;
   logic        out_valid;
   logic [63:0] out_rdata;
   logic [4:0]  out_rd;
   logic        out_err;

   ysyx_22041412_lsu dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
      .in_func3(in_func3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .out_valid(out_valid), .out_rdata(out_rdata),
      .out_rd(out_rd), .out_err(out_err)
   );

   initial forever #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int n_acc = 0;
   int n_done = 0;
   int acc_cyc = 0;
   int mem_cyc = 0;

   // Model expectations for the op in flight
   logic        exp_mem_valid = 1'b0;
   logic        exp_err = 1'b0;
   logic        exp_we = 1'b0;
   logic [63:0] exp_addr = 64'd0;
   logic [63:0] exp_wdata = 64'd0;
   logic [7:0]  exp_wmask = 8'd0;
   logic [63:0] exp_rdata = 64'd0;
   logic [4:0]  exp_rd = 5'd0;
   int          exp_lat = 0;

   // Values captured from the DUT by the compare process
   logic [63:0] last_mem_addr = 64'd0;
   logic [63:0] last_mem_wdata = 64'd0;
   logic [7:0]  last_mem_wmask = 8'd0;
   logic [63:0] last_rdata = 64'd0;
   logic [4:0]  last_rd = 5'd0;
   logic        last_err = 1'b0;
   int          last_lat = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference model: byte-lane view of one access.
   task automatic model(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rdat,
                        input logic [4:0] rd, input int rdly, input int vdly);
      int size;
      int off;
      logic ill;
      logic [63:0] v;
      size = 1 << f3[1:0];
      off  = int'(a[2:0]);
      ill  = (ld == st) || (st && f3[2]) || (ld && (f3 == 3'b111));
      exp_err   = ill || ((a % 64'(size)) != 64'd0);
      exp_addr  = a - 64'(off);
      exp_we    = st && !ld;
      exp_wmask = 8'd0;
      exp_wdata = wd << (8 * off);
      v = 64'd0;
      if (!exp_err) begin
         for (int i = 0; i < size; i++) begin
            if (exp_we) exp_wmask[off + i] = 1'b1;
            v[8*i +: 8] = rdat[8*(off + i) +: 8];
         end
         if (!f3[2] && (size < 8) && v[8*size - 1]) begin
            for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
         end
      end
      exp_rdata = (exp_err || exp_we) ? 64'd0 : v;
      exp_rd    = rd;
      exp_lat   = exp_err ? 1 : (exp_we ? rdly + 2 : rdly + vdly + 3);
   endtask

   // Compare process: checks DUT against model every cycle outside reset.
   initial begin : cmp
      bit busy;
      bit clr;
      int seen;
      busy = 1'b0;
      clr  = 1'b0;
      seen = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy = 1'b0;
            clr  = 1'b0;
            seen = n_acc;
         end else begin
            if (clr) begin
               busy = 1'b0;
               clr  = 1'b0;
            end
            if (seen != n_acc) begin
               busy = 1'b1;
               seen = n_acc;
            end
            check("in_ready", 64'(in_ready), 64'(!busy));
            check("mem_valid", 64'(mem_valid), 64'(exp_mem_valid));
            if (mem_valid) begin
               mem_cyc++;
               check("mem_addr", mem_addr, exp_addr);
               check("mem_we", 64'(mem_we), 64'(exp_we));
               check("mem_wmask", 64'(mem_wmask), 64'(exp_wmask));
               if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
               last_mem_addr  = mem_addr;
               last_mem_wdata = mem_wdata;
               last_mem_wmask = mem_wmask;
            end
            if (!busy) begin
               check("out_valid_idle", 64'(out_valid), 64'd0);
            end else if (out_valid) begin
               check("out_err", 64'(out_err), 64'(exp_err));
               check("out_rdata", out_rdata, exp_rdata);
               check("out_rd", 64'(out_rd), 64'(exp_rd));
               check("latency", 64'(cyc - acc_cyc + 1), 64'(exp_lat));
               last_rdata = out_rdata;
               last_rd    = out_rd;
               last_err   = out_err;
               last_lat   = cyc - acc_cyc + 1;
               clr = 1'b1;
               n_done++;
            end
         end
      end
   end

   task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd, input logic [4:0] rd,
                        input int rdly, input int vdly, input logic [63:0] rdat, input bit spur);
      int d0;
      d0 = n_done;
      model(ld, st, f3, a, wd, rdat, rd, rdly, vdly);
      @(posedge clk); #1;
      in_valid = 1'b1; in_load = ld; in_store = st; in_func3 = f3;
      in_addr = a; in_wdata = wd; in_rd = rd;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_acc++;
      acc_cyc = cyc;
      if (!exp_err) begin
         exp_mem_valid = 1'b1;
         for (int i = 0; i < rdly; i++) begin
            mem_ready = 1'b0; mem_rvalid = spur; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
            @(posedge clk); #1;
         end
         mem_rvalid = 1'b0; mem_ready = 1'b1;
         @(posedge clk); #1;
         mem_ready = 1'b0;
         exp_mem_valid = 1'b0;
         if (!exp_we) begin
            for (int i = 0; i < vdly; i++) begin
               @(posedge clk); #1;
            end
            mem_rvalid = 1'b1; mem_rdata = rdat;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
         end
      end
      for (int i = 0; i < 60 && n_done == d0; i++) @(posedge clk);
      #1;
      check("completion", 64'(n_done - d0), 64'd1);
      $display("op ld=%0b st=%0b f3=%0d addr=%h rd=%0d -> err=%0b rdata=%h lat=%0d",
               ld, st, f3, a, rd, last_err, last_rdata, last_lat);
   endtask

   initial begin
      int m0;
      int d0;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_mem_valid", 64'(mem_valid), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_err", 64'(out_err), 64'd0);
      check("rst_mem_addr", mem_addr, 64'd0);
      check("rst_mem_wdata", mem_wdata, 64'd0);
      check("rst_mem_wmask", 64'(mem_wmask), 64'd0);
      check("rst_out_rdata", out_rdata, 64'd0);
      check("rst_out_rd", 64'(out_rd), 64'd0);
      rst = 1'b0;

      // Aligned sh
      do_op(1'b0, 1'b1, 3'b001, 64'h8000_0006, 64'h1234, 5'd5, 0, 0, 64'd0, 1'b0);
      check("sh_addr", last_mem_addr, 64'h8000_0000);
      check("sh_wmask", 64'(last_mem_wmask), 64'hC0);
      check("sh_wdata", last_mem_wdata, 64'h1234_0000_0000_0000);
      check("sh_err", 64'(last_err), 64'd0);
      check("sh_lat", 64'(last_lat), 64'd2);

      // lb / lbu with 3 wait cycles before rvalid
      do_op(1'b1, 1'b0, 3'b000, 64'h8000_1003, 64'd0, 5'd7, 0, 3, 64'h0000_0000_8000_0000, 1'b0);
      check("lb_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      check("lb_rd", 64'(last_rd), 64'd7);
      do_op(1'b1, 1'b0, 3'b100, 64'h8000_1003, 64'd0, 5'd8, 0, 3, 64'h0000_0000_8000_0000, 1'b0);
      check("lbu_rdata", last_rdata, 64'h80);
      check("lbu_rd", 64'(last_rd), 64'd8);

      // Misaligned lw and ld: no memory request
      m0 = mem_cyc;
      do_op(1'b1, 1'b0, 3'b010, 64'h8000_2002, 64'd0, 5'd9, 0, 0, 64'd0, 1'b0);
      check("lw_mis_err", 64'(last_err), 64'd1);
      check("lw_mis_rdata", last_rdata, 64'd0);
      check("lw_mis_lat", 64'(last_lat), 64'd1);
      do_op(1'b1, 1'b0, 3'b011, 64'h8000_2004, 64'd0, 5'd10, 0, 0, 64'd0, 1'b0);
      check("ld_mis_err", 64'(last_err), 64'd1);
      check("mis_no_mem", 64'(mem_cyc - m0), 64'd0);

      // Store under 5 cycles of backpressure
      do_op(1'b0, 1'b1, 3'b010, 64'h8000_3004, 64'hDEAD_BEEF, 5'd11, 5, 0, 64'd0, 1'b0);
      check("bp_lat", 64'(last_lat), 64'd7);
      check("bp_wmask", 64'(last_mem_wmask), 64'hF0);
      check("bp_wdata", last_mem_wdata, 64'hDEAD_BEEF_0000_0000);

      // Illegal ops, then a spurious rvalid while idle
      do_op(1'b1, 1'b0, 3'b111, 64'h8000_4000, 64'd0, 5'd12, 0, 0, 64'd0, 1'b0);
      check("ill_f3_err", 64'(last_err), 64'd1);
      do_op(1'b1, 1'b1, 3'b011, 64'h8000_4000, 64'd0, 5'd13, 0, 0, 64'd0, 1'b0);
      check("ill_both_err", 64'(last_err), 64'd1);
      do_op(1'b0, 1'b1, 3'b100, 64'h8000_4000, 64'd0, 5'd14, 0, 0, 64'd0, 1'b0);
      @(posedge clk); #1;
      mem_rvalid = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      @(posedge clk); #1;

      // lh with spurious rvalid during REQ, then other sizes
      do_op(1'b1, 1'b0, 3'b001, 64'h8000_5006, 64'd0, 5'd15, 2, 1, 64'hFEDC_BA98_7654_3210, 1'b1);
      check("lh_spur_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FEDC);
      do_op(1'b1, 1'b0, 3'b101, 64'h8000_5002, 64'd0, 5'd16, 0, 0, 64'hFEDC_BA98_7654_3210, 1'b0);
      do_op(1'b1, 1'b0, 3'b010, 64'h8000_5004, 64'd0, 5'd17, 1, 2, 64'hFEDC_BA98_7654_3210, 1'b0);
      do_op(1'b1, 1'b0, 3'b110, 64'h8000_5000, 64'd0, 5'd18, 0, 0, 64'hFEDC_BA98_F654_3210, 1'b0);
      do_op(1'b1, 1'b0, 3'b011, 64'h8000_5008, 64'd0, 5'd19, 0, 0, 64'h0123_4567_89AB_CDEF, 1'b0);
      do_op(1'b0, 1'b1, 3'b000, 64'h8000_6007, 64'h0000_00AB, 5'd20, 1, 0, 64'd0, 1'b0);
      check("sb_wmask", 64'(last_mem_wmask), 64'h80);
      check("sb_wdata", last_mem_wdata, 64'hAB00_0000_0000_0000);
      do_op(1'b0, 1'b1, 3'b011, 64'h8000_6008, 64'h1122_3344_5566_7788, 5'd21, 0, 0, 64'd0, 1'b0);

      // Reset while waiting for read data
      d0 = n_done;
      model(1'b1, 1'b0, 3'b011, 64'h8000_7010, 64'd0, 64'd0, 5'd22, 0, 0);
      @(posedge clk); #1;
      in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_func3 = 3'b011;
      in_addr = 64'h8000_7010; in_rd = 5'd22;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_acc++;
      acc_cyc = cyc;
      exp_mem_valid = 1'b1;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      exp_mem_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      check("mid_rst_mem_valid", 64'(mem_valid), 64'd0);
      check("mid_rst_mem_we", 64'(mem_we), 64'd0);
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_mem_addr", mem_addr, 64'd0);
      check("mid_rst_out_rdata", out_rdata, 64'd0);
      check("mid_rst_out_rd", 64'(out_rd), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("mid_rst_no_out", 64'(n_done - d0), 64'd0);
      $display("op reset during WAIT_R -> completions=%0d", n_done - d0);

      // Recovery after reset
      do_op(1'b1, 1'b0, 3'b000, 64'h8000_8001, 64'd0, 5'd23, 0, 0, 64'h0000_0000_0000_7F00, 1'b0);
      check("post_rst_lb", last_rdata, 64'h7F);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ysyx_22041412_lsu.md
# ysyx_22041412_lsu

Load/store unit for the ysyx_22041412 RV64 core. Takes the effective address produced by the execute-stage ALU (base + offset for load/store opcodes), plus funct3 and store data, and runs one data-memory transaction on a valid/ready request and response bus. Returns extended load data or store completion to writeback. Raises an error instead of accessing memory for misaligned or illegal requests.

## Interface
- No parameters. Data/address width is fixed at 64 bits and the memory bus is 8 bytes wide.
- clk  in  1  core clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  EX stage presents a memory op
- in_ready  out  1  LSU can accept; high only in IDLE
- in_load  in  1  op is a load
- in_store  in  1  op is a store
- in_func3  in  3  RV funct3 (size/sign)
- in_addr  in  64  effective address from the ALU
- in_wdata  in  64  store data, rs2, LSB-justified
- in_rd  in  5  destination register tag
- mem_valid  out  1  request valid
- mem_ready  in  1  memory accepts request
- mem_we  out  1  1 = write
- mem_addr  out  64  in_addr with [2:0] forced to 0
- mem_wdata  out  64  lane-shifted store data
- mem_wmask  out  8  byte enables; 0 for reads
- mem_rvalid  in  1  read data valid
- mem_rdata  in  64  aligned 8-byte read data
- out_valid  out  1  one-cycle completion pulse
- out_rdata  out  64  extended load data; 0 for stores and errors
- out_rd  out  5  tag of the completing op
- out_err  out  1  misaligned or illegal op; qualified by out_valid

## Operation
- States: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch all in_* fields.
  - Illegal op goes to DONE with err=1. Illegal means any of:
    - in_load==in_store;
    - a store with func3[2]=1;
    - a load with func3=111.
  - Misaligned op goes to DONE with err=1. Misaligned means addr is not a multiple of the access size (size = 1<<func3[1:0]).
  - Otherwise the op goes to REQ.
- REQ:
  - mem_valid=1.
  - mem_we, mem_addr, mem_wdata and mem_wmask are held stable until mem_ready.
  - On mem_valid&&mem_ready: a store goes to DONE; a load goes to WAIT_R.
- WAIT_R:
  - mem_valid=0.
  - On mem_rvalid, capture the extended data and go to DONE.
  - mem_rvalid outside WAIT_R is ignored.
- DONE:
  - out_valid=1 for exactly one cycle, with out_rdata, out_rd and out_err.
  - Then go to IDLE.
- Store lanes, with o = addr[2:0]:
  - mem_wdata = in_wdata << (8*o).
  - mem_wmask = {01, 03, 0F, FF}[func3[1:0]] << o.
- Load extract: byte field = mem_rdata >> (8*o), truncated to the access size.
  - lb/lh/lw: sign-extend to 64.
  - lbu/lhu/lwu: zero-extend.
  - ld: unchanged.
- Aligned accesses never cross an 8-byte line, so there is no split transaction.
- One transaction in flight at most. There is no store buffer.

## Timing
- Reset: state=IDLE.
  - in_ready=1.
  - mem_valid, mem_we, out_valid and out_err are 0.
  - mem_addr, mem_wdata, mem_wmask, out_rdata and out_rd are all 0.
- Reset mid-transaction abandons the op. mem_valid falls asynchronously with rst, and a later mem_rvalid is ignored.
- Accept in cycle N:
  - REQ from N+1.
  - If mem_ready is high in cycle M (M≥N+1), a store gives out_valid in M+1.
  - For a load, mem_rvalid in cycle K (K≥M+1) gives out_valid in K+1.
- Best case: store 2 cycles and load 3 cycles from acceptance to out_valid.
- Error path: out_valid in N+1 with out_err=1. No mem_valid is ever raised.
- in_ready is 0 from N+1 until the cycle after out_valid, when IDLE is re-entered. Back-to-back ops are therefore spaced at least 3 cycles (store).
- mem_ready held low keeps REQ indefinitely, with outputs stable and no timeout.
- All outputs are registered (Moore). No combinational path exists from in_* or mem_* to outputs.

## Test plan
- **Aligned store:** sh, addr=0x8000_0006, wdata=0x1234, mem_ready=1 immediately.
  - mem_addr=0x8000_0000, wmask=0xC0, wdata=0x1234_0000_0000_0000.
  - out_valid 2 cycles after accept, err=0.
- **Signed and unsigned byte loads:** addr=0x…03 with mem_rdata=0x0000_0000_8000_0000 returned after 3 wait cycles.
  - lb gives out_rdata=0xFFFF_FFFF_FFFF_FF80; lbu gives 0x80.
  - Check the out_rd tag on each.
- **Misaligned:** lw at addr=0x…02 and ld at addr=0x…04.
  - No mem_valid pulse.
  - out_valid one cycle after accept, err=1, rdata=0.
- **Backpressure:** store with mem_ready held low 5 cycles.
  - mem_valid and all mem_* stay stable.
  - in_ready stays 0.
  - Completes one cycle after the ready cycle.
- **Illegal and spurious inputs:** func3=111 load, and in_load=in_store=1.
  - Both give err=1.
  - An mem_rvalid injected while IDLE/REQ is ignored.
- **Reset mid-load:** assert rst during WAIT_R.
  - All outputs go to reset values immediately.
  - A following mem_rvalid produces no out_valid.
